// File: rtl/dma_apb_test_sequencer.sv
// Autonomous APB master that programs, reads back and polls a multi-channel DMAC
// for bring-up runs. One FSM per channel; a round-robin arbiter shares the APB port.

module dma_apb_seq_ch #(
    parameter int          CH_IDX       = 0,
    parameter int          TESTS_PER_CH = 32,
    parameter logic [31:0] XFER_LEN     = 32'h100,
    parameter logic [31:0] SRC_BASE     = 32'h0,
    parameter logic [31:0] DST_STRIDE   = 32'h2000,
    parameter int unsigned CH_SFR_SIZE  = 'h100,
    parameter int          POLL_GAP     = 100,
    parameter int          ADDR_W       = 12
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              go,
    input  logic              abort,
    input  logic              done,
    input  logic [31:0]       prdata,
    output logic              req,
    output logic [ADDR_W-1:0] addr,
    output logic              write,
    output logic [31:0]       wdata,
    output logic              mis,
    output logic              stat_ok,
    output logic              fin
);
    localparam int IW = $clog2(TESTS_PER_CH + 1);
    localparam int GW = $clog2(POLL_GAP + 1);
    localparam logic [ADDR_W-1:0] SFR_BASE = ADDR_W'(CH_SFR_SIZE * (CH_IDX + 1));
    localparam logic [31:0]       DST_BASE = DST_STRIDE * 32'(CH_IDX + 1);

    typedef enum logic [3:0] {
        IDLE, WR_SRC, RD_SRC, WR_DST, RD_DST, WR_LEN, RD_LEN, WR_CMD, GAP, RD_STAT, FIN
    } ch_state_e;

    ch_state_e         state_q, state_d;
    logic [IW-1:0]     iter_q;
    logic [GW-1:0]     gap_q;
    logic [31:0]       src_q, dst_q, expv;
    logic [ADDR_W-1:0] off;
    logic              rb, last_iter;

    assign last_iter = (iter_q == IW'(TESTS_PER_CH - 1));
    assign addr      = SFR_BASE + off;
    assign mis       = done & rb & (prdata != expv);
    assign stat_ok   = done & (state_q == RD_STAT) & (prdata == 32'd1);
    assign fin       = (state_q == FIN);

    always_comb begin
        req   = 1'b1;
        write = 1'b0;
        off   = '0;
        wdata = '0;
        expv  = '0;
        rb    = 1'b0;
        case (state_q)
            WR_SRC:  begin write = 1'b1; wdata = src_q; end
            RD_SRC:  begin rb = 1'b1; expv = src_q; end
            WR_DST:  begin write = 1'b1; off = ADDR_W'(8'h04); wdata = dst_q; end
            RD_DST:  begin rb = 1'b1; off = ADDR_W'(8'h04); expv = dst_q; end
            WR_LEN:  begin write = 1'b1; off = ADDR_W'(8'h08); wdata = XFER_LEN; end
            RD_LEN:  begin rb = 1'b1; off = ADDR_W'(8'h08); expv = XFER_LEN; end
            WR_CMD:  begin write = 1'b1; off = ADDR_W'(8'h0C); wdata = 32'd1; end
            RD_STAT: off = ADDR_W'(8'h10);
            default: req = 1'b0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        if (go) begin
            state_d = WR_SRC;
        end else if (abort && state_q != IDLE) begin
            state_d = FIN;
        end else if (state_q == GAP) begin
            if (gap_q == GW'(POLL_GAP - 1)) state_d = RD_STAT;
        end else if (done && req) begin
            case (state_q)
                WR_SRC:  state_d = RD_SRC;
                RD_SRC:  state_d = WR_DST;
                WR_DST:  state_d = RD_DST;
                RD_DST:  state_d = WR_LEN;
                WR_LEN:  state_d = RD_LEN;
                RD_LEN:  state_d = WR_CMD;
                WR_CMD:  state_d = GAP;
                RD_STAT: state_d = (prdata == 32'd1) ? (last_iter ? FIN : WR_SRC) : GAP;
                default: state_d = state_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state_q <= IDLE;
            iter_q  <= '0;
            gap_q   <= '0;
            src_q   <= '0;
            dst_q   <= '0;
        end else begin
            state_q <= state_d;
            gap_q   <= (state_q == GAP && state_d == GAP) ? gap_q + GW'(1) : '0;
            if (go) begin
                iter_q <= '0;
                src_q  <= SRC_BASE;
                dst_q  <= DST_BASE;
            end else if (stat_ok && !abort) begin
                iter_q <= iter_q + IW'(1);
                src_q  <= src_q + XFER_LEN;
                dst_q  <= dst_q + XFER_LEN;
            end
        end
    end
endmodule

module dma_apb_test_sequencer #(
    parameter int          NUM_CH       = 4,
    parameter int          TESTS_PER_CH = 32,
    parameter logic [31:0] XFER_LEN     = 32'h100,
    parameter logic [31:0] SRC_BASE     = 32'h0,
    parameter logic [31:0] DST_STRIDE   = 32'h2000,
    parameter int unsigned CH_SFR_SIZE  = 'h100,
    parameter int          POLL_GAP     = 100,
    parameter int          ADDR_W       = 12
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_i,
    output logic              psel_o,
    output logic              penable_o,
    output logic [ADDR_W-1:0] paddr_o,
    output logic              pwrite_o,
    output logic [31:0]       pwdata_o,
    input  logic              pready_i,
    input  logic [31:0]       prdata_i,
    input  logic              pslverr_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              error_o,
    output logic [1:0]        err_code_o,
    output logic [2:0]        err_ch_o,
    output logic [15:0]       xfer_cnt_o
);
    localparam int CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    typedef enum logic [1:0] {A_IDLE, A_SETUP, A_ACCESS} apb_state_e;

    logic [NUM_CH-1:0]             ch_req, ch_write, ch_mis, ch_stat_ok, ch_fin, ch_done;
    logic [NUM_CH-1:0][ADDR_W-1:0] ch_addr;
    logic [NUM_CH-1:0][31:0]       ch_wdata;

    apb_state_e        apb_q, apb_d;
    logic [CW-1:0]     gnt_q, ptr_q, pick;
    logic              found, go, xfer_done, err_now, cnt_inc, all_fin;
    logic [ADDR_W-1:0] paddr_q;
    logic [31:0]       pwdata_q;
    logic              pwrite_q, busy_q, done_q, error_q;
    logic [1:0]        err_code_q;
    logic [2:0]        err_ch_q;
    logic [15:0]       xfer_cnt_q;

    assign go        = start_i & ~busy_q;
    assign xfer_done = (apb_q == A_ACCESS) & pready_i;
    assign err_now   = xfer_done & (pslverr_i | ch_mis[gnt_q]);
    assign cnt_inc   = ch_stat_ok[gnt_q] & ~err_now;
    assign all_fin   = &ch_fin;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        assign ch_done[c] = xfer_done & (gnt_q == CW'(c));
        dma_apb_seq_ch #(
            .CH_IDX(c), .TESTS_PER_CH(TESTS_PER_CH), .XFER_LEN(XFER_LEN),
            .SRC_BASE(SRC_BASE), .DST_STRIDE(DST_STRIDE), .CH_SFR_SIZE(CH_SFR_SIZE),
            .POLL_GAP(POLL_GAP), .ADDR_W(ADDR_W)
        ) u_ch (
            .clk(clk), .rst_n(rst_n), .go(go), .abort(err_now), .done(ch_done[c]),
            .prdata(prdata_i), .req(ch_req[c]), .addr(ch_addr[c]), .write(ch_write[c]),
            .wdata(ch_wdata[c]), .mis(ch_mis[c]), .stat_ok(ch_stat_ok[c]), .fin(ch_fin[c])
        );
    end

    // ptr_q is the highest-priority channel; it moves past each winner.
    always_comb begin
        found = 1'b0;
        pick  = ptr_q;
        for (int k = 0; k < NUM_CH; k++) begin
            if (!found && ch_req[(int'(ptr_q) + k) % NUM_CH]) begin
                found = 1'b1;
                pick  = CW'((int'(ptr_q) + k) % NUM_CH);
            end
        end
    end

    always_comb begin
        apb_d = apb_q;
        case (apb_q)
            A_IDLE:   if (busy_q && found) apb_d = A_SETUP;
            A_SETUP:  apb_d = A_ACCESS;
            A_ACCESS: if (pready_i) apb_d = A_IDLE;
            default:  apb_d = A_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            apb_q    <= A_IDLE;
            gnt_q    <= '0;
            ptr_q    <= '0;
            paddr_q  <= '0;
            pwrite_q <= 1'b0;
            pwdata_q <= '0;
        end else begin
            apb_q <= apb_d;
            if (apb_q == A_IDLE && apb_d == A_SETUP) begin
                gnt_q    <= pick;
                ptr_q    <= (int'(pick) == NUM_CH - 1) ? '0 : pick + CW'(1);
                paddr_q  <= ch_addr[pick];
                pwrite_q <= ch_write[pick];
                pwdata_q <= ch_wdata[pick];
            end
        end
    end

    // Only the first error is latched: busy drops with it, so later ones are never seen.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
            err_code_q <= '0;
            err_ch_q   <= '0;
            xfer_cnt_q <= '0;
        end else if (go) begin
            busy_q     <= 1'b1;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
            err_code_q <= '0;
            err_ch_q   <= '0;
            xfer_cnt_q <= '0;
        end else if (busy_q) begin
            if (err_now) begin
                busy_q     <= 1'b0;
                done_q     <= 1'b1;
                error_q    <= 1'b1;
                err_code_q <= pslverr_i ? 2'd1 : 2'd2;
                err_ch_q   <= 3'(gnt_q);
            end else begin
                if (cnt_inc) xfer_cnt_q <= xfer_cnt_q + 16'd1;
                if (all_fin) begin
                    busy_q <= 1'b0;
                    done_q <= 1'b1;
                end
            end
        end
    end

    assign psel_o     = (apb_q != A_IDLE);
    assign penable_o  = (apb_q == A_ACCESS);
    assign paddr_o    = paddr_q;
    assign pwrite_o   = pwrite_q;
    assign pwdata_o   = pwdata_q;
    assign busy_o     = busy_q;
    assign done_o     = done_q;
    assign error_o    = error_q;
    assign err_code_o = err_code_q;
    assign err_ch_o   = err_ch_q;
    assign xfer_cnt_o = xfer_cnt_q;
endmodule

// File: tb/tb_dma_apb_test_sequencer.sv
// Directed bench: a 1-channel/1-test instance with an echoing slave, and a default
// instance against a slave with delayed ready, STAT polling, corruption and pslverr.

module tb_dma_apb_test_sequencer;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    // default-parameter instance
    logic        start, psel, penable, pwrite, pready, pslverr, busy, done, error;
    logic [11:0] paddr;
    logic [31:0] pwdata, prdata;
    logic [1:0]  err_code;
    logic [2:0]  err_ch;
    logic [15:0] xfer_cnt;

    // single-channel, single-test instance
    logic        start_s, psel_s, penable_s, pwrite_s, pready_s, pslverr_s, busy_s, done_s, error_s;
    logic [11:0] paddr_s;
    logic [31:0] pwdata_s, prdata_s;
    logic [1:0]  err_code_s;
    logic [2:0]  err_ch_s;
    logic [15:0] xfer_cnt_s;

    dma_apb_test_sequencer u_dut (
        .clk(clk), .rst_n(rst_n), .start_i(start), .psel_o(psel), .penable_o(penable),
        .paddr_o(paddr), .pwrite_o(pwrite), .pwdata_o(pwdata), .pready_i(pready),
        .prdata_i(prdata), .pslverr_i(pslverr), .busy_o(busy), .done_o(done),
        .error_o(error), .err_code_o(err_code), .err_ch_o(err_ch), .xfer_cnt_o(xfer_cnt)
    );

    dma_apb_test_sequencer #(.NUM_CH(1), .TESTS_PER_CH(1)) u_small (
        .clk(clk), .rst_n(rst_n), .start_i(start_s), .psel_o(psel_s), .penable_o(penable_s),
        .paddr_o(paddr_s), .pwrite_o(pwrite_s), .pwdata_o(pwdata_s), .pready_i(pready_s),
        .prdata_i(prdata_s), .pslverr_i(pslverr_s), .busy_o(busy_s), .done_o(done_s),
        .error_o(error_s), .err_code_o(err_code_s), .err_ch_o(err_ch_s), .xfer_cnt_o(xfer_cnt_s)
    );

    // ---------------- slave models ----------------
    logic [31:0] mem   [0:4095];
    logic [31:0] mem_s [0:4095];
    int          pcnt  [8];
    logic [1:0]  wcnt = 2'd0;
    logic        rand_ready = 1'b0, hold_ready = 1'b0;
    int          zero_polls = 0;
    logic [11:0] corrupt_addr = 12'hFFF, err_addr = 12'hFFF;
    logic [2:0]  sch;

    assign sch     = 3'(paddr[11:8] - 4'd1);
    assign pready  = ~hold_ready & (wcnt == 2'd0);
    assign pslverr = psel & penable & (paddr == err_addr);
    assign prdata  = (paddr[7:0] == 8'h10) ? ((pcnt[sch] >= zero_polls) ? 32'd1 : 32'd0)
                   : (mem[paddr] ^ ((paddr == corrupt_addr) ? 32'd1 : 32'd0));

    assign pready_s  = 1'b1;
    assign pslverr_s = 1'b0;
    assign prdata_s  = (paddr_s[7:0] == 8'h10) ? 32'd1 : mem_s[paddr_s];

    always @(posedge clk) begin
        if (psel && !penable) wcnt <= rand_ready ? 2'($urandom_range(0, 3)) : 2'd0;
        else if (psel && penable && wcnt != 2'd0) wcnt <= wcnt - 2'd1;
        if (psel && penable && pready) begin
            if (pwrite) mem[paddr] <= pwdata;
            else if (paddr[7:0] == 8'h10) pcnt[sch] <= (pcnt[sch] >= zero_polls) ? 0 : pcnt[sch] + 1;
        end
        if (psel_s && penable_s && pready_s && pwrite_s) mem_s[paddr_s] <= pwdata_s;
    end

    // ---------------- protocol / transfer monitors ----------------
    int          n_xfer = 0, n_setup = 0, viol = 0;
    logic [11:0] first_addr [5];
    logic        pv_psel = 1'b0, pv_pen = 1'b0, pv_rdy = 1'b0, pv_wr = 1'b0;
    logic [11:0] pv_addr = '0;
    logic [31:0] pv_wd = '0;

    always @(negedge clk) begin
        if (penable && !psel) viol++;
        if (psel && !penable) begin
            n_setup++;
            if (pv_psel) viol++;
        end
        if (psel && penable) begin
            if (!pv_psel || (pv_pen && pv_rdy)) viol++;
            if (paddr != pv_addr || pwrite != pv_wr || pwdata != pv_wd) viol++;
            if (pready) begin
                if (n_xfer < 5) first_addr[n_xfer] = paddr;
                n_xfer++;
            end
        end
        pv_psel = psel; pv_pen = penable; pv_rdy = pready;
        pv_addr = paddr; pv_wr = pwrite; pv_wd = pwdata;
    end

    int          n_s = 0, idle_s = 0, last_idle_s = 0;
    logic [11:0] s_addr [16];
    logic        s_wr   [16];
    logic [31:0] s_wd   [16];

    always @(negedge clk) begin
        if (!psel_s) idle_s++;
        else if (!penable_s) begin
            last_idle_s = idle_s;
            idle_s = 0;
        end
        if (psel_s && penable_s && pready_s && n_s < 16) begin
            s_addr[n_s] = paddr_s; s_wr[n_s] = pwrite_s; s_wd[n_s] = pwdata_s;
            n_s++;
        end
    end

    // ---------------- checking helpers ----------------
    int checks = 0, errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic pulse_start();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int maxc);
        int k = 0;
        while (!done && k < maxc) begin
            @(negedge clk);
            k++;
        end
        check(tag, 32'(done), 32'd1);
    endtask

    localparam logic [11:0] S_ADDR [8] = '{12'h100, 12'h100, 12'h104, 12'h104,
                                           12'h108, 12'h108, 12'h10C, 12'h110};
    localparam logic        S_WR   [8] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    localparam logic [31:0] S_WD   [8] = '{32'h0, 32'h0, 32'h2000, 32'h0,
                                           32'h100, 32'h0, 32'h1, 32'h0};
    localparam logic [11:0] ARB    [5] = '{12'h100, 12'h200, 12'h300, 12'h400, 12'h100};

    initial begin
        int k;
        int mark;
        rst_n = 1'b1; start = 1'b0; start_s = 1'b0;
        repeat (3) @(negedge clk);

        // reset state
        check("rst_psel", 32'(psel), 0);
        check("rst_penable", 32'(penable), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_error", 32'(error), 0);
        check("rst_xfer_cnt", 32'(xfer_cnt), 0);
        check("rst_psel_s", 32'(psel_s), 0);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);

        // single channel, single test, always-ready echo slave
        @(negedge clk) start_s = 1'b1;
        @(negedge clk) start_s = 1'b0;
        check("s_busy", 32'(busy_s), 1);
        k = 0;
        while (!done_s && k < 1000) begin @(negedge clk); k++; end
        check("s_done", 32'(done_s), 1);
        check("s_error", 32'(error_s), 0);
        check("s_busy_end", 32'(busy_s), 0);
        check("s_xfer_cnt", 32'(xfer_cnt_s), 1);
        check("s_n_xfers", 32'(n_s), 8);
        for (int i = 0; i < 8; i++) begin
            check($sformatf("s_addr%0d", i), 32'(s_addr[i]), 32'(S_ADDR[i]));
            check($sformatf("s_wr%0d", i), 32'(s_wr[i]), 32'(S_WR[i]));
            if (S_WR[i]) check($sformatf("s_wd%0d", i), s_wd[i], S_WD[i]);
        end
        // POLL_GAP idle cycles plus the arbitration cycle before the STAT read
        check("s_poll_gap", 32'(last_idle_s >= 100 && last_idle_s <= 101), 1);

        // default run: STAT=0 for 3 polls, random ready delay
        zero_polls = 3; rand_ready = 1'b1;
        pulse_start();
        check("run_busy", 32'(busy), 1);
        check("run_done_clr", 32'(done), 0);
        wait_done("run_done", 60000);
        check("run_error", 32'(error), 0);
        check("run_busy_end", 32'(busy), 0);
        check("run_xfer_cnt", 32'(xfer_cnt), 128);
        check("run_apb_xfers", 32'(n_xfer), 1408);
        check("ch2_last_src", mem[12'h300], 32'h1F00);
        check("ch2_last_dst", mem[12'h304], 32'h7F00);
        check("ch2_len", mem[12'h308], 32'h100);
        for (int i = 0; i < 5; i++)
            check($sformatf("arb_order%0d", i), 32'(first_addr[i]), 32'(ARB[i]));
        check("protocol_viol", 32'(viol), 0);

        // corrupted ch1 DST readback
        corrupt_addr = 12'h204;
        pulse_start();
        wait_done("mis_done", 5000);
        check("mis_error", 32'(error), 1);
        check("mis_code", 32'(err_code), 2);
        check("mis_ch", 32'(err_ch), 1);
        check("mis_busy", 32'(busy), 0);
        check("mis_xfer_cnt", 32'(xfer_cnt), 0);
        mark = n_setup;
        repeat (200) @(negedge clk);
        check("mis_no_setup", 32'(n_setup), 32'(mark));
        corrupt_addr = 12'hFFF;

        // pslverr on ch3 CMD write, then rerun
        err_addr = 12'h40C;
        pulse_start();
        wait_done("slv_done", 5000);
        check("slv_error", 32'(error), 1);
        check("slv_code", 32'(err_code), 1);
        check("slv_ch", 32'(err_ch), 3);
        err_addr = 12'hFFF;
        pulse_start();
        check("rerun_busy", 32'(busy), 1);
        check("rerun_done", 32'(done), 0);
        check("rerun_error", 32'(error), 0);
        check("rerun_code", 32'(err_code), 0);
        check("rerun_ch", 32'(err_ch), 0);
        k = 0;
        while (xfer_cnt == 16'd0 && k < 3000) begin @(negedge clk); k++; end
        check("rerun_progress", 32'(xfer_cnt != 16'd0), 1);

        // reset during a stalled ACCESS phase
        hold_ready = 1'b1;
        k = 0;
        while (!penable && k < 2000) begin @(negedge clk); k++; end
        check("stall_access", 32'(penable), 1);
        rst_n = 1'b1;
        #1;
        check("arst_psel", 32'(psel), 0);
        check("arst_penable", 32'(penable), 0);
        check("arst_busy", 32'(busy), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b0; hold_ready = 1'b0;
        mark = n_setup;
        repeat (300) @(negedge clk);
        check("post_rst_no_setup", 32'(n_setup), 32'(mark));
        check("post_rst_busy", 32'(busy), 0);
        check("post_rst_done", 32'(done), 0);

        // full run after reset
        pulse_start();
        check("final_busy", 32'(busy), 1);
        wait_done("final_done", 60000);
        check("final_error", 32'(error), 0);
        check("final_xfer_cnt", 32'(xfer_cnt), 128);
        check("final_protocol_viol", 32'(viol), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/dma_apb_test_sequencer.md
Name: dma_apb_test_sequencer

Overview:
Synthesizable APB master that programs and drives a multi-channel DMA controller's SFRs autonomously, for on-chip bring-up and regression. Per channel it runs a configurable number of transfers: write SRC/DST/LEN, read back each, write CMD=1, then poll STAT until completion. Channels run concurrently and share one APB master through a round-robin arbiter. It sits between a test-control register (start/status) and the DMAC APB slave port. Data comparison is out of scope.

Parameters:
NUM_CH, 4, number of DMA channels driven (1..8)
TESTS_PER_CH, 32, transfers issued per channel
XFER_LEN, 32'h100, byte length per transfer; also the SRC/DST increment
SRC_BASE, 32'h0, first source address, shared by all channels
DST_STRIDE, 32'h2000, channel c destination base = (c+1)*DST_STRIDE
CH_SFR_SIZE, 12'h100, channel c SFR base = (c+1)*CH_SFR_SIZE
POLL_GAP, 100, idle cycles between STAT polls of one channel
ADDR_W, 12, APB address width

Ports:
clk  in  1  clock
rst_n  in  1  reset: asynchronous, active-high
start_i  in  1  pulse; starts a run when idle
psel_o  out  1  APB select
penable_o  out  1  APB enable
paddr_o  out  ADDR_W  APB address
pwrite_o  out  1  APB write
pwdata_o  out  32  APB write data
pready_i  in  1  APB ready
prdata_i  in  32  APB read data
pslverr_i  in  1  APB slave error
busy_o  out  1  run in progress
done_o  out  1  run finished (pass or fail); sticky until next start
error_o  out  1  run aborted on error; sticky until next start
err_code_o  out  2  0 none, 1 pslverr, 2 readback mismatch
err_ch_o  out  3  channel that raised the error
xfer_cnt_o  out  16  total completed transfers, all channels

Behaviour:
- Reset: all outputs 0; all channel FSMs in IDLE; arbiter pointer = 0; counters cleared. Reset is honoured mid-APB-transfer: psel_o/penable_o drop immediately.
- start_i while busy_o=1 is ignored. start_i while idle: clear done_o/error_o/err_code_o/err_ch_o/xfer_cnt_o, set busy_o, move every channel to WR_SRC with iteration index 0.
- Channel FSM: IDLE, WR_SRC, RD_SRC, WR_DST, RD_DST, WR_LEN, RD_LEN, WR_CMD, GAP, RD_STAT, FIN. Each non-GAP/IDLE/FIN state raises one APB request; the state advances only when its transfer completes.
- Addresses: base=(c+1)*CH_SFR_SIZE; SRC +0x0, DST +0x4, LEN +0x8, CMD +0xC, STAT +0x10. For iteration i: src=SRC_BASE+i*XFER_LEN, dst=(c+1)*DST_STRIDE+i*XFER_LEN, len=XFER_LEN, CMD data=1. Arithmetic is 32-bit, wrapping.
- Readback (RD_SRC/DST/LEN): prdata_i != value written -> error code 2.
- WR_CMD -> GAP; GAP counts POLL_GAP cycles -> RD_STAT. STAT==1: xfer_cnt_o+1, i+1; i==TESTS_PER_CH -> FIN, else WR_SRC. STAT!=1 -> GAP.
- Arbiter: one APB transfer at a time; at the end of a transfer the grant goes to the next requesting channel after the last granted one (round-robin). A request is never preempted.
- APB: SETUP cycle (psel=1, penable=0), then ACCESS (psel=1, penable=1), held until pready_i=1. paddr/pwrite/pwdata are stable for the whole transfer. After completion psel drops for ≥1 cycle before the next SETUP. Minimum 3 cycles per transfer.
- Error (pslverr_i=1 at completion, or mismatch): latch err_code_o/err_ch_o from the first error only. All channels go to FIN and no new SETUP is issued. busy_o=0; done_o=error_o=1 the next cycle.
- All channels in FIN without error: busy_o=0, done_o=1 the next cycle.
- A single error and a completion in the same cycle: the error wins.

Test Plan:
- NUM_CH=1, TESTS_PER_CH=1, pready=1, echoing slave, STAT=1 on first read -> APB sequence W100=0, R100, W104=2000, R104, W108=100, R108, W10C=1, then 100 idle cycles, R110; done_o=1, error_o=0, xfer_cnt_o=1.
- Default params, slave returns STAT=0 for 3 polls then 1, with pready randomly delayed 0-3 cycles -> 128 transfers, xfer_cnt_o=128. Channel 2 last src=1F00, dst=6000+1F00. No overlapping psel.
- 4 channels requesting at once -> grants in order 0,1,2,3,0; never two transfers in flight.
- Slave corrupts readback of ch1 DST -> error_o=1, err_code_o=2, err_ch_o=1; no SETUP after the failing transfer.
- pslverr_i=1 on ch3 WR_CMD -> err_code_o=1, err_ch_o=3. A later start_i clears the flags and reruns.
- Assert rst_n during an ACCESS phase with pready low -> psel_o/penable_o are 0 immediately. After release, the block idles until start_i.
